// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with an internal 16x oversample tick and a valid/ready byte output.
// Optional feature: define UART_RX_PARITY_EN to receive a parity bit after the data bits
// (PARITY_ODD selects odd parity) and report mismatches on parity_err.
module uart_rx #(
  parameter int unsigned CLOCK      = 100000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int unsigned Div  = CLOCK / (BAUD_RATE * 16);
  localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned BitW = $clog2(DATA_BITS) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
`ifdef UART_RX_PARITY_EN
    ,
    StParity
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [DivW-1:0]        tick_cnt_q;
  logic                   tick;
  logic [3:0]             sample_cnt_q, sample_cnt_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_good, frame_bad;
  logic                   mid_tick, full_tick, last_bit;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   parity_err_q, parity_err_d;
`endif

  assign tick      = (tick_cnt_q == DivW'(Div - 1));
  assign mid_tick  = tick && (sample_cnt_q == 4'd7);
  assign full_tick = tick && (sample_cnt_q == 4'd15);
  assign last_bit  = (bit_cnt_q == BitW'(DATA_BITS - 1));

  // Two-flop synchronizer on rx (idles high) and free-running oversample divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_cnt_q <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + DivW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (!rx_s_q) state_d = StStart;
      // A start bit that is high again at its midpoint was a glitch.
      StStart:    if (mid_tick) state_d = rx_s_q ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
      StData:     if (full_tick && last_bit) state_d = StParity;
      StParity:   if (full_tick) state_d = StStop;
`else
      StData:     if (full_tick && last_bit) state_d = StStop;
`endif
      StStop:     if (full_tick) state_d = rx_s_q ? StIdle : StWaitHigh;
      // Hold off until the line is released so a break is not decoded as frames.
      StWaitHigh: if (rx_s_q) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Counters, shift register and output handshake.
  always_comb begin
    sample_cnt_d = tick ? sample_cnt_q + 4'd1 : sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    frame_good   = 1'b0;
    frame_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      StIdle: sample_cnt_d = '0;
      StStart: begin
        if (mid_tick && !rx_s_q) begin
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
        end
      end
      StData: begin
        if (full_tick) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BitW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: if (full_tick) par_d = rx_s_q;
`endif
      StStop: begin
        if (full_tick) begin
          frame_good = rx_s_q;
          frame_bad  = !rx_s_q;
        end
      end
      default: ;
    endcase

    rx_valid_d = rx_valid_q && !rx_ready;
    rx_data_d  = rx_data_q;
    overrun_d  = 1'b0;
    if (frame_good) begin
      // Load only if the holding slot is free or being emptied this cycle.
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    frame_err_d = frame_bad;
`ifdef UART_RX_PARITY_EN
    parity_err_d = frame_good && ((^shift_q ^ par_q) != PARITY_ODD);
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
